// File: rtl/regf_wb.sv
// rtl/regf_wb.sv - regf writeback: merges ALU results with queued load results onto one write port
// Optional feature macro REGF_WB_BYPASS_EN: a load skips the empty, idle queue straight to the port.
module regf_wb #(
  parameter int FIFO_DEPTH = 4,
  parameter int XLEN       = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alu_valid,
  input  logic [4:0]                    alu_rd,
  input  logic [XLEN-1:0]               alu_data,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [4:0]                    mem_rd,
  input  logic [XLEN-1:0]               mem_data,
  output logic                          we,
  output logic [4:0]                    waddr,
  output logic [XLEN-1:0]               wdata,
  output logic [31:0]                   pending,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]      rd_q   [FIFO_DEPTH];
  logic [4:0]      rd_d   [FIFO_DEPTH];
  logic [XLEN-1:0] data_q [FIFO_DEPTH];
  logic [XLEN-1:0] data_d [FIFO_DEPTH];
  logic            kill_q [FIFO_DEPTH];
  logic            kill_d [FIFO_DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            we_q, we_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [31:0]     pending_c;
  logic            accept, bypass, push, pop, occ;
  logic [PW-1:0]   off;

  assign mem_ready  = rst_n && (count_q != CW'(FIFO_DEPTH));
  assign we         = we_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign pending    = pending_c;
  assign fifo_count = count_q;

  always_comb begin
    rd_d      = rd_q;
    data_d    = data_q;
    kill_d    = kill_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    pending_c = '0;
    off       = '0;
    occ       = 1'b0;
    accept    = mem_valid && mem_ready;
`ifdef REGF_WB_BYPASS_EN
    bypass    = accept && !alu_valid && (count_q == '0);
`else
    bypass    = 1'b0;
`endif
    push      = accept && !bypass;
    pop       = !alu_valid && (count_q != '0);

    // Only slots between rptr and rptr+count hold live or killed entries.
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off = PW'(i) - rptr_q;
      occ = CW'(off) < count_q;
      if (occ && alu_valid && (alu_rd != 5'd0) && (rd_q[i] == alu_rd))
        kill_d[i] = 1'b1;
      if (occ && !kill_q[i])
        pending_c[rd_q[i]] = 1'b1;
    end
    pending_c[0] = 1'b0;

    if (push) begin
      rd_d[wptr_q]   = mem_rd;
      data_d[wptr_q] = mem_data;
      kill_d[wptr_q] = 1'b0;
      wptr_d         = wptr_q + PW'(1);
    end
    if (pop)
      rptr_d = rptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (alu_valid) begin
      if (alu_rd != 5'd0) begin
        we_d    = 1'b1;
        waddr_d = alu_rd;
        wdata_d = alu_data;
      end
    end else if (pop) begin
      if (!kill_q[rptr_q] && (rd_q[rptr_q] != 5'd0)) begin
        we_d    = 1'b1;
        waddr_d = rd_q[rptr_q];
        wdata_d = data_q[rptr_q];
      end
    end else if (bypass) begin
      if (mem_rd != 5'd0) begin
        we_d    = 1'b1;
        waddr_d = mem_rd;
        wdata_d = mem_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '{default: '0};
      data_q  <= '{default: '0};
      kill_q  <= '{default: 1'b0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      rd_q    <= rd_d;
      data_q  <= data_d;
      kill_q  <= kill_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end
endmodule

// File: tb/tb_regf_wb.sv
// tb/tb_regf_wb.sv - directed self-checking bench for regf_wb
// Honors REGF_WB_BYPASS_EN when compiled with it.
module tb_regf_wb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] pending;
  logic [2:0]  fifo_count;

  int n_tests = 0;
  int n_fail  = 0;

  regf_wb #(.FIFO_DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .we(we), .waddr(waddr), .wdata(wdata),
    .pending(pending), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    mem_valid = mv;
    mem_rd    = mrd;
    mem_data  = md;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    step;
    step;
    check("rst_we", we, 0);
    check("rst_count", fifo_count, 0);
    check("rst_pending", pending, 0);
    check("rst_ready", mem_ready, 0);
    rst_n = 1'b1;
    #1;
    check("rel_ready", mem_ready, 1);

    // ALU latency 1
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
    step;
    drive(0, 0, 0, 0, 0, 0);
    check("alu_we", we, 1);
    check("alu_waddr", waddr, 5);
    check("alu_wdata", wdata, 32'hDEADBEEF);

    // Single load, no ALU
    drive(0, 0, 0, 1, 7, 32'h1234);
    #1;
    check("ld_pend_pre", pending, 0);
    step;
    drive(0, 0, 0, 0, 0, 0);
`ifdef REGF_WB_BYPASS_EN
    check("ld_byp_we", we, 1);
    check("ld_byp_waddr", waddr, 7);
    check("ld_byp_wdata", wdata, 32'h1234);
    check("ld_byp_count", fifo_count, 0);
`else
    check("ld_n1_we", we, 0);
    check("ld_n1_count", fifo_count, 1);
    check("ld_n1_pending", pending, 32'h0000_0080);
    step;
    check("ld_n2_we", we, 1);
    check("ld_n2_waddr", waddr, 7);
    check("ld_n2_wdata", wdata, 32'h1234);
    check("ld_n2_count", fifo_count, 0);
    check("ld_n2_pending", pending, 0);
`endif

    // Continuous ALU starves the queue until it fills
    for (int k = 0; k < 6; k++) begin
      drive(1, 5'(10 + k), 32'(k), 1, 5'(20 + k), 32'(32'h100 + k));
      #1;
      check($sformatf("fill_ready%0d", k), mem_ready, (k < 4) ? 1 : 0);
      step;
      check($sformatf("fill_we%0d", k), we, 1);
      check($sformatf("fill_waddr%0d", k), waddr, 10 + k);
    end
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("full_count", fifo_count, 4);
    check("full_pending", pending, 32'h00F0_0000);
    check("full_ready", mem_ready, 0);
    for (int j = 0; j < 4; j++) begin
      step;
      check($sformatf("drain_we%0d", j), we, 1);
      check($sformatf("drain_waddr%0d", j), waddr, 20 + j);
      check($sformatf("drain_wdata%0d", j), wdata, 32'h100 + j);
    end
    step;
    check("drain_idle_we", we, 0);
    check("drain_count", fifo_count, 0);

    // WAW kill: load rd=3 queued behind ALU, then ALU rd=3
    drive(1, 9, 32'h99, 1, 3, 32'h55);
    step;
    check("kill_a_waddr", waddr, 9);
    check("kill_a_pending", pending, 32'h0000_0008);
    drive(1, 3, 32'hA, 0, 0, 0);
    step;
    check("kill_b_we", we, 1);
    check("kill_b_waddr", waddr, 3);
    check("kill_b_wdata", wdata, 32'hA);
    check("kill_b_count", fifo_count, 1);
    check("kill_b_pending", pending, 0);
    drive(0, 0, 0, 0, 0, 0);
    step;
    check("kill_c_we", we, 0);
    check("kill_c_count", fifo_count, 0);
    check("kill_c_wdata", wdata, 32'hA);

    // Push and ALU to the same rd: pushed entry survives
    drive(1, 4, 32'h1, 1, 4, 32'h2);
    step;
    drive(0, 0, 0, 0, 0, 0);
    check("same_alu_wdata", wdata, 32'h1);
    check("same_pending", pending, 32'h0000_0010);
    step;
    check("same_ld_we", we, 1);
    check("same_ld_waddr", waddr, 4);
    check("same_ld_wdata", wdata, 32'h2);

    // rd=0 from both sources
    drive(1, 0, 32'h77, 1, 0, 32'h88);
    step;
    drive(0, 0, 0, 0, 0, 0);
    check("x0_alu_we", we, 0);
    check("x0_count", fifo_count, 1);
    check("x0_pending", pending, 0);
    step;
    check("x0_ld_we", we, 0);
    check("x0_count2", fifo_count, 0);
    check("x0_hold_wdata", wdata, 32'h2);

    // Reset mid-stream with 3 queued loads
    for (int k = 0; k < 3; k++) begin
      drive(1, 5'(1 + k), 32'(k), 1, 5'(11 + k), 32'(k));
      step;
    end
    check("pre_rst_count", fifo_count, 3);
    check("pre_rst_pending", pending, 32'h0000_3800);
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", we, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_pending", pending, 0);
    check("mid_rst_ready", mem_ready, 0);
    step;
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", mem_ready, 1);
    step;
    check("post_rst_we", we, 0);
    check("post_rst_count", fifo_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
